// File: rtl/conv_scheduler.sv
// conv_scheduler: round-robin arbiter that shares one external binary-to-BCD
// divisor among N_REQ requesters. It grants one requester, restarts the divisor
// with the latched operand, waits for listo (or a watchdog timeout) and returns
// the four BCD digits with a one-cycle ack.
// Optional build macro: CONV_SAT_EN. When it is defined, operands above 9999
// are clamped to 9999 and ovf_o is flagged with the ack.
//
// Handshake: req_i[k] is a level held until ack_o[k] pulses for one cycle.
// ack_o is the valid for digits_o/ovf_o/err_o. There is no back-pressure.
// The requester drops req_i in the cycle after its ack; a request still high
// in the following IDLE cycle counts as a new request.
module conv_scheduler #(
  parameter int N_REQ    = 3,
  parameter int WDOG_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [16*N_REQ-1:0]  operand_i,
  output logic [N_REQ-1:0]     ack_o,
  output logic [15:0]          digits_o,
  output logic                 ovf_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 div_rst_o,
  output logic [15:0]          div_num_o,
  input  logic                 div_listo_i,
  input  logic [3:0]           div_mil_i,
  input  logic [3:0]           div_cen_i,
  input  logic [3:0]           div_dec_i,
  input  logic [3:0]           div_uni_i,
  output logic [1:0]           dbg_state_o
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [15:0]      op_q, op_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [15:0]      digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             div_rst_q, div_rst_d;

  logic [15:0]      op_arr [N_REQ];
  logic [GW:0]      cand;
  logic [GW-1:0]    win_idx;
  logic             win_found;
  logic [15:0]      win_raw;
  logic [15:0]      win_op;
  logic             win_ovf;

  for (genvar k = 0; k < N_REQ; k++) begin : g_op
    assign op_arr[k] = operand_i[16*k +: 16];
  end

  // Round-robin pick: first set request searching upward from ptr+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_raw   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (!win_found && req_i[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
        win_raw   = op_arr[cand[GW-1:0]];
      end
    end
  end

`ifdef CONV_SAT_EN
  assign win_ovf = (win_raw > 16'd9999);
  assign win_op  = win_ovf ? 16'd9999 : win_raw;
`else
  assign win_ovf = 1'b0;
  assign win_op  = win_raw;
`endif

  // Next-state and next-output computation for the IDLE/LOAD/WAIT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    op_d     = op_q;
    wdog_d   = wdog_q;
    ack_d    = '0;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          op_d    = win_op;
          ovf_d   = win_ovf;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_listo_i) begin
          digits_d        = {div_mil_i, div_cen_i, div_dec_i, div_uni_i};
          ack_d[grant_q]  = 1'b1;
          state_d         = S_DONE;
        end else if (wdog_q == 8'(WDOG_MAX)) begin
          digits_d        = '0;
          err_d           = 1'b1;
          ack_d[grant_q]  = 1'b1;
          state_d         = S_DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_DONE: begin
        ptr_d   = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    div_rst_d = (state_d == S_LOAD);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered outputs; reset holds the divisor in reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= GW'(N_REQ-1);
      grant_q   <= '0;
      op_q      <= '0;
      wdog_q    <= '0;
      ack_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      wdog_q    <= wdog_d;
      ack_q     <= ack_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      div_rst_q <= div_rst_d;
    end
  end

  assign ack_o       = ack_q;
  assign digits_o    = digits_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign div_rst_o   = div_rst_q;
  assign div_num_o   = op_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: directed table plus hand-written sequences for
// conv_scheduler, with a behavioural stand-in for the external divisor.
module tb_conv_scheduler;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_i;
  logic [16*N-1:0] operand_i;
  logic [N-1:0]  ack_o;
  logic [15:0]   digits_o;
  logic          ovf_o, err_o, busy_o;
  logic          div_rst, div_listo;
  logic [15:0]   div_num;
  logic [3:0]    div_mil, div_cen, div_dec, div_uni;
  logic [1:0]    dbg_state;

  int errors;
  int checks;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  conv_scheduler #(.N_REQ(N), .WDOG_MAX(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .operand_i   (operand_i),
    .ack_o       (ack_o),
    .digits_o    (digits_o),
    .ovf_o       (ovf_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .div_rst_o   (div_rst),
    .div_num_o   (div_num),
    .div_listo_i (div_listo),
    .div_mil_i   (div_mil),
    .div_cen_i   (div_cen),
    .div_dec_i   (div_dec),
    .div_uni_i   (div_uni),
    .dbg_state_o (dbg_state)
  );

  // ---------------- divisor stand-in ----------------
  // Repeated-subtraction divisor: listo appears 5+S cycles after the reset
  // edge, S = thousands + hundreds + tens steps; thousands counter is 4 bits.
  logic        m_run = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_dig = '0;
  logic        force_no_listo;

  function automatic int model_steps(input logic [15:0] n);
    int v;
    v = int'(n);
    return v / 1000 + (v % 1000) / 100 + (v % 100) / 10;
  endfunction

  function automatic logic [15:0] model_digits(input logic [15:0] n);
    int v;
    logic [3:0] m, c, d, u;
    v = int'(n);
    m = 4'((v / 1000) % 16);
    c = 4'((v % 1000) / 100);
    d = 4'((v % 100) / 10);
    u = 4'(v % 10);
    return {m, c, d, u};
  endfunction

  always @(posedge clk) begin
    if (div_rst) begin
      m_run <= 1'b1;
      m_cnt <= 5 + model_steps(div_num);
      m_dig <= model_digits(div_num);
    end else if (m_run) begin
      if (m_cnt == 0) m_run <= 1'b0;
      else            m_cnt <= m_cnt - 1;
    end
  end

  assign div_listo = m_run && (m_cnt == 0) && !force_no_listo;
  assign div_mil   = m_dig[15:12];
  assign div_cen   = m_dig[11:8];
  assign div_dec   = m_dig[7:4];
  assign div_uni   = m_dig[3:0];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  logic [15:0] ops [N];

  task automatic set_ops();
    operand_i = {ops[2], ops[1], ops[0]};
  endtask

  // Raise one request with its operand; other slices carry junk.
  task automatic start_req(input int idx, input logic [15:0] op);
    for (int k = 0; k < N; k++) ops[k] = 16'hBEEF;
    ops[idx] = op;
    set_ops();
    req_i = 3'b001 << idx;
  endtask

  // Count negedges until any ack appears, bounded by budget.
  task automatic wait_ack(input int budget, output logic [N-1:0] a, output int lat);
    lat = 0;
    a = '0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (ack_o != '0) begin
        a = ack_o;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [15:0] op;
    logic [15:0] num;
    logic [15:0] dig;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vt [6];

  // scoreboard for the continuous round-robin sequence
  logic [N-1:0] exp_q [$];

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] e;
    int lat;
    logic seen;

    errors = 0;
    checks = 0;

    vt[0] = '{0, 16'd1234,  16'd1234,  16'h1234, 1'b0, 14};
    vt[1] = '{1, 16'd0,     16'd0,     16'h0000, 1'b0, 8};
    vt[2] = '{2, 16'd9999,  16'd9999,  16'h9999, 1'b0, 35};
`ifdef CONV_SAT_EN
    vt[3] = '{1, 16'd65535, 16'd9999,  16'h9999, 1'b1, 35};
`else
    vt[3] = '{1, 16'd65535, 16'd65535, 16'h1535, 1'b0, 81};
`endif
    vt[4] = '{2, 16'd4070,  16'd4070,  16'h4070, 1'b0, 19};
`ifdef CONV_SAT_EN
    vt[5] = '{0, 16'd10000, 16'd9999,  16'h9999, 1'b1, 35};
`else
    vt[5] = '{0, 16'd10000, 16'd10000, 16'hA000, 1'b0, 18};
`endif

    // ---- reset block ----
    rst = 1'b0;
    req_i = '0;
    operand_i = '0;
    force_no_listo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack",     32'(ack_o),     32'd0);
    check("rst_digits",  32'(digits_o),  32'd0);
    check("rst_ovf",     32'(ovf_o),     32'd0);
    check("rst_err",     32'(err_o),     32'd0);
    check("rst_busy",    32'(busy_o),    32'd0);
    check("rst_div_rst", 32'(div_rst),   32'd1);
    check("rst_div_num", 32'(div_num),   32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_div_rst", 32'(div_rst), 32'd0);

    // ---- table: single requests ----
    for (int i = 0; i < 6; i++) begin
      start_req(vt[i].idx, vt[i].op);
      @(negedge clk);
      check($sformatf("v%0d_load_rst", i),  32'(div_rst), 32'd1);
      check($sformatf("v%0d_load_num", i),  32'(div_num), 32'(vt[i].num));
      check($sformatf("v%0d_load_busy", i), 32'(busy_o),  32'd1);
      wait_ack(400, a, lat);
      lat = lat + 1;
      check($sformatf("v%0d_ack", i), 32'(a), 32'(3'b001 << vt[i].idx));
      check($sformatf("v%0d_dig", i), 32'(digits_o), 32'(vt[i].dig));
      check($sformatf("v%0d_ovf", i), 32'(ovf_o), 32'(vt[i].ovf));
      check($sformatf("v%0d_err", i), 32'(err_o), 32'd0);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      req_i = '0;
      @(negedge clk);
      check($sformatf("v%0d_ack_clr", i), 32'(ack_o),  32'd0);
      check($sformatf("v%0d_idle", i),    32'(busy_o), 32'd0);
    end

    // ---- simultaneous req0/req2 from reset ----
    do_reset();
    ops[0] = 16'd0; ops[1] = 16'hBEEF; ops[2] = 16'd9999;
    set_ops();
    req_i = 3'b101;
    wait_ack(400, a, lat);
    check("sim_ack0", 32'(a), 32'h1);
    check("sim_dig0", 32'(digits_o), 32'h0000);
    check("sim_lat0", 32'(lat), 32'd8);
    req_i = 3'b100;
    wait_ack(400, a, lat);
    check("sim_ack2", 32'(a), 32'h4);
    check("sim_dig2", 32'(digits_o), 32'h9999);
    check("sim_lat2", 32'(lat), 32'd36);
    req_i = '0;
    @(negedge clk);

    // ---- all requests held: round-robin order ----
    do_reset();
    ops[0] = 16'd5; ops[1] = 16'd6; ops[2] = 16'd7;
    set_ops();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    req_i = 3'b111;
    for (int g = 0; g < 6; g++) begin
      wait_ack(400, a, lat);
      e = exp_q.pop_front();
      check($sformatf("rr%0d_ack", g), 32'(a), 32'(e));
      check($sformatf("rr%0d_dig", g), 32'(digits_o), 32'(g % 3 + 5));
      check($sformatf("rr%0d_lat", g), 32'(lat), (g == 0) ? 32'd8 : 32'd9);
    end
    req_i = '0;
    @(negedge clk);

    // ---- watchdog timeout, then normal conversion ----
    force_no_listo = 1'b1;
    start_req(0, 16'd42);
    wait_ack(400, a, lat);
    check("wd_ack", 32'(a), 32'h1);
    check("wd_err", 32'(err_o), 32'd1);
    check("wd_dig", 32'(digits_o), 32'd0);
    check("wd_lat", 32'(lat), 32'd258);
    req_i = '0;
    force_no_listo = 1'b0;
    @(negedge clk);
    start_req(1, 16'd1234);
    wait_ack(400, a, lat);
    check("wd_next_ack", 32'(a), 32'h2);
    check("wd_next_err", 32'(err_o), 32'd0);
    check("wd_next_dig", 32'(digits_o), 32'h1234);
    check("wd_next_lat", 32'(lat), 32'd14);
    req_i = '0;
    @(negedge clk);

    // ---- reset during WAIT ----
    start_req(0, 16'd9999);
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_state", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    req_i = '0;
    #1;
    check("mid_rst_ack",     32'(ack_o),    32'd0);
    check("mid_rst_busy",    32'(busy_o),   32'd0);
    check("mid_rst_digits",  32'(digits_o), 32'd0);
    check("mid_rst_err",     32'(err_o),    32'd0);
    check("mid_rst_div_rst", 32'(div_rst),  32'd1);
    check("mid_rst_div_num", 32'(div_num),  32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o != '0) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ack_o != '0) seen = 1'b1;
    end
    check("mid_no_ack", 32'(seen), 32'd0);
    start_req(0, 16'd9999);
    wait_ack(400, a, lat);
    check("mid_redo_ack", 32'(a), 32'h1);
    check("mid_redo_dig", 32'(digits_o), 32'h9999);
    check("mid_redo_lat", 32'(lat), 32'd35);
    req_i = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
